// File: rtl/cic_comp_fir.sv
// 15-tap symmetric CIC droop-compensation FIR.
// One folded pre-add/multiply/accumulate per cycle for 8 cycles, then round and saturate.
module cic_comp_fir #(
  parameter int IN_WIDTH   = 38,
  parameter int IN_SHIFT   = 20,
  parameter int DATA_WIDTH = 18,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 38,
  parameter int OUT_SHIFT  = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        nd,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        rdy,
  output logic                        busy,
  output logic                        drop,
  output logic                        sat
);

  localparam int NTAPS      = 15;
  localparam int PRE_WIDTH  = DATA_WIDTH + 1;
  localparam int PROD_WIDTH = PRE_WIDTH + COEF_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [ACC_WIDTH-1:0] ROUND_BIAS =
    {{(ACC_WIDTH-OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Left half of the symmetric response; h[14-j] mirrors h[j].
  function automatic logic signed [COEF_WIDTH-1:0] coef(input logic [2:0] idx);
    logic signed [COEF_WIDTH-1:0] c;
    case (idx)
      3'd0:    c = COEF_WIDTH'(-1);
      3'd2:    c = COEF_WIDTH'(5);
      3'd4:    c = COEF_WIDTH'(-19);
      3'd6:    c = COEF_WIDTH'(78);
      3'd7:    c = COEF_WIDTH'(130);
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [2:0]                   idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] taps_q [NTAPS];
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
  logic                         rdy_q, rdy_d;
  logic                         busy_q, busy_d;
  logic                         drop_q, drop_d;
  logic                         sat_q, sat_d;
  logic                         shift_en;

  logic signed [DATA_WIDTH-1:0] x_new;
  logic [3:0]                   mirror_idx;
  logic signed [DATA_WIDTH-1:0] tap_lo, tap_hi;
  logic signed [PRE_WIDTH-1:0]  pre_sum;
  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  rounded;

  // Truncating rescale: upper bits beyond DATA_WIDTH are assumed redundant sign bits.
  assign x_new      = DATA_WIDTH'(din >>> IN_SHIFT);
  assign mirror_idx = 4'd14 - {1'b0, idx_q};
  assign tap_lo     = taps_q[{1'b0, idx_q}];
  assign tap_hi     = (idx_q == 3'd7) ? '0 : taps_q[mirror_idx];
  assign pre_sum    = PRE_WIDTH'(tap_lo) + PRE_WIDTH'(tap_hi);
  assign product    = PROD_WIDTH'(pre_sum) * PROD_WIDTH'(coef(idx_q));
  assign rounded    = (acc_q + ROUND_BIAS) >>> OUT_SHIFT;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    rdy_d    = 1'b0;
    sat_d    = 1'b0;
    shift_en = 1'b0;
    drop_d   = drop_q | (nd & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (nd) begin
          shift_en = 1'b1;
          acc_d    = '0;
          idx_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_WIDTH'(product);
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_OUT;
      end
      S_OUT: begin
        if (rounded > OUT_MAX) begin
          dout_d = OUT_MAX[OUT_WIDTH-1:0];
          sat_d  = 1'b1;
        end else if (rounded < OUT_MIN) begin
          dout_d = OUT_MIN[OUT_WIDTH-1:0];
          sat_d  = 1'b1;
        end else begin
          dout_d = rounded[OUT_WIDTH-1:0];
        end
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the sample buffer is reset along with the rest of the state so the first outputs after reset are well defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < NTAPS; i++) taps_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      sat_q   <= sat_d;
      if (shift_en) begin
        taps_q[0] <= x_new;
        for (int i = 1; i < NTAPS; i++) taps_q[i] <= taps_q[i-1];
      end
    end
  end

  assign dout = dout_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;
  assign drop = drop_q;
  assign sat  = sat_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: vector table with hand-computed outputs plus
// reset-abort, overrun and OUT-cycle drop sequences.
module tb_cic_comp_fir;

  logic               clk = 1'b0;
  logic               rst;
  logic               nd;
  logic signed [37:0] din;
  logic signed [15:0] dout;
  logic               rdy, busy, drop, sat;

  cic_comp_fir dut (
    .clk  (clk),
    .rst  (rst),
    .nd   (nd),
    .din  (din),
    .dout (dout),
    .rdy  (rdy),
    .busy (busy),
    .drop (drop),
    .sat  (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [37:0] din;
    int                 exp_dout;
    bit                 exp_sat;
    bit                 chk;
  } vec_t;

  typedef struct {
    int dout;
    bit sat;
  } out_t;

  vec_t vecs[$];
  out_t mon_q[$];

  always @(negedge clk) if (rdy) mon_q.push_back('{dout: int'(dout), sat: sat});

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic signed [37:0] din_of(input int x);
    logic signed [37:0] d;
    d = 38'(x);
    return d <<< 20;
  endfunction

  task automatic add_vec(input logic signed [37:0] d, input int e, input bit s, input bit c);
    vecs.push_back('{din: d, exp_dout: e, exp_sat: s, chk: c});
  endtask

  // Direct-form reference used for the overrun sequence.
  int hcoef[15] = '{-1, 0, 5, 0, -19, 0, 78, 130, 78, 0, -19, 0, 5, 0, -1};
  int hist[15];

  task automatic model_push(input int x, output int y, output bit s);
    longint acc;
    for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < 15; k++) acc += longint'(hcoef[k]) * longint'(hist[k]);
    acc = (acc + 128) >>> 8;
    s = 1'b0;
    if (acc > 32767) begin acc = 32767; s = 1'b1; end
    else if (acc < -32768) begin acc = -32768; s = 1'b1; end
    y = int'(acc);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; nd = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 exactly 12 cycles after its nd.
  task automatic send_vec(input int idx, input vec_t v);
    int k, lat;
    k  = cyc;
    nd = 1'b1; din = v.din;
    @(posedge clk); #1;
    nd = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy) begin lat = cyc - k; break; end
    end
    check($sformatf("vec%0d latency", idx), lat, 10);
    if (v.chk) begin
      check($sformatf("vec%0d dout", idx), dout, v.exp_dout);
      check($sformatf("vec%0d sat", idx), sat, v.exp_sat);
    end
    while (cyc < k + 12) begin @(posedge clk); #1; end
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int imp[14] = '{0, 5, 0, -19, 0, 78, 130, 78, 0, -19, 0, 5, 0, -1};
    int i128[8] = '{0, 0, 3, 0, -9, 0, 39, 65};
    int neg1[8] = '{0, 0, 0, 0, 0, 0, 0, -1};
    int ovr[10] = '{300, -200, 1000, 50, -700, 2000, 123, -4000, 77, 9};
    int exp_y[$];
    bit exp_s[$];
    int y, k, rdy_seen;
    bit s;

    rst = 1'b1; nd = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset dout", dout, 0);
    check("reset rdy", rdy, 0);
    check("reset busy", busy, 0);
    check("reset drop", drop, 0);
    check("reset sat", sat, 0);

    // Reset asserted mid-MAC aborts the sequence.
    nd = 1'b1; din = din_of(5000);
    @(posedge clk); #1;
    nd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("busy mid-MAC", busy, 1);
    rst = 1'b1;
    #1 check("busy async reset", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rdy_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy) rdy_seen++;
    end
    check("abort no rdy", rdy_seen, 0);
    check("abort dout", dout, 0);
    check("abort busy", busy, 0);
    check("abort drop", drop, 0);
    @(posedge clk); #1;

    // Impulse x=256 reproduces the coefficients.
    add_vec(din_of(256), -1, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) add_vec(din_of(0), imp[i], 1'b0, 1'b1);
    // DC gain.
    for (int i = 0; i < 20; i++) add_vec(din_of(1000), 1000, 1'b0, i >= 14);
    // Saturation both ways.
    for (int i = 0; i < 16; i++) add_vec(din_of(131071), 32767, 1'b1, i >= 14);
    for (int i = 0; i < 16; i++) add_vec(din_of(-131072), -32768, 1'b1, i >= 14);
    // Flush, then x=128 impulse exercising rounding.
    for (int i = 0; i < 15; i++) add_vec(din_of(0), 0, 1'b0, i == 14);
    add_vec(din_of(128), i128[0], 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) add_vec(din_of(0), i128[i], 1'b0, 1'b1);
    // Flush, then din=-1 truncates to x=-1.
    for (int i = 0; i < 15; i++) add_vec(din_of(0), 0, 1'b0, i == 14);
    add_vec('1, neg1[0], 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) add_vec(din_of(0), neg1[i], 1'b0, 1'b1);

    foreach (vecs[i]) send_vec(i, vecs[i]);
    check("no drop at 12-cycle spacing", drop, 0);

    // Overrun: 5-cycle spacing, every second sample dropped.
    do_reset();
    foreach (hist[i]) hist[i] = 0;
    mon_q.delete();
    for (int i = 0; i < 10; i++) begin
      nd = 1'b1; din = din_of(ovr[i]);
      @(posedge clk); #1;
      nd = 1'b0;
      if (i == 1) check("drop set on overrun", drop, 1);
      repeat (4) begin @(posedge clk); #1; end
      if (i % 2 == 0) begin
        model_push(ovr[i], y, s);
        exp_y.push_back(y);
        exp_s.push_back(s);
      end
    end
    repeat (30) begin @(posedge clk); #1; end
    check("overrun rdy count", mon_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("overrun out%0d dout", i), mon_q[i].dout, exp_y[i]);
        check($sformatf("overrun out%0d sat", i), mon_q[i].sat, exp_s[i]);
      end
    end
    check("drop sticky", drop, 1);

    // nd in the OUT cycle is dropped.
    do_reset();
    check("drop cleared by reset", drop, 0);
    mon_q.delete();
    k = cyc;
    nd = 1'b1; din = din_of(256);
    @(posedge clk); #1;
    nd = 1'b0;
    while (cyc < k + 9) begin @(posedge clk); #1; end
    check("busy in OUT", busy, 1);
    nd = 1'b1; din = din_of(1000);
    @(posedge clk); #1;
    nd = 1'b0;
    check("rdy at nd+10", rdy, 1);
    check("dout at nd+10", dout, -1);
    check("busy after OUT", busy, 0);
    check("drop on OUT nd", drop, 1);
    repeat (20) begin @(posedge clk); #1; end
    check("OUT nd ignored", mon_q.size(), 1);
    check("dout held", dout, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
